// File: rtl/cic_dec_ctrl_if.sv
// Control/status bundle between the DSP control registers and the CIC sequencer.
// master: register/control side, slave: cic_dec_ctrl.
interface cic_dec_ctrl_if;
    logic       enable;
    logic       strobe_in;
    logic [7:0] rate_in;
    logic       rate_stb;
    logic       strobe_int;
    logic       strobe_cic;
    logic       clear_out;
    logic [4:0] shift;
    logic [7:0] rate_active;
    logic       busy;

    modport master (
        output enable, strobe_in, rate_in, rate_stb,
        input  strobe_int, strobe_cic, clear_out, shift, rate_active, busy
    );

    modport slave (
        input  enable, strobe_in, rate_in, rate_stb,
        output strobe_int, strobe_cic, clear_out, shift, rate_active, busy
    );
endinterface

// File: rtl/cic_dec_ctrl.sv
// Sequencer for a 4-stage CIC decimator: integrator enable, decimated output strobe,
// boundary-aligned rate changes with integrator/comb clear, and output bit-gain shift.
// Optional feature macro: CIC_DEC_CTRL_FLUSH_EN -- suppresses FLUSH_OUTS decimated outputs
// after every rate change that clears the datapath.
module cic_dec_ctrl #(
    parameter logic [7:0]  DEFAULT_RATE = 8'd4,
    parameter int unsigned FLUSH_OUTS   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    cic_dec_ctrl_if.slave     ctrl
);

    localparam int unsigned RATE_W  = 8;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned SHIFT_W = 5;
    localparam logic [RATE_W-1:0] RATE_MAX = 8'd128;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // Bit growth of a 4-stage CIC: ceil(4*log2(r)) == ceil(log2(r^4)).
    function automatic logic [SHIFT_W-1:0] bitgain(input logic [RATE_W-1:0] r);
        logic [31:0]        p;
        logic [SHIFT_W-1:0] s;
        p = 32'(r) * 32'(r) * 32'(r) * 32'(r);
        s = 5'd28;
        for (int i = 27; i >= 0; i--) begin
            if ((32'd1 << i) >= p) s = 5'(i);
        end
        return s;
    endfunction

    // Clamp requested rate into the legal 1..128 range.
    function automatic logic [RATE_W-1:0] coerce(input logic [RATE_W-1:0] r);
        if (r == '0)           return 8'd1;
        else if (r > RATE_MAX) return RATE_MAX;
        else                   return r;
    endfunction

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RATE_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                sint_q, sint_d;
    logic                scic_q, scic_d;
    logic                clr_q, clr_d;
    logic                busy_q, busy_d;

    logic                boundary_c;
    logic                apply_c;
    logic                change_c;
    logic                flush_act_c;
    logic [CNT_W-1:0]    reload_c;

    // Last input sample of a decimation block.
    assign boundary_c = ctrl.enable & ctrl.strobe_in & (cnt_q == '0);
    // Pending rate takes effect on a boundary, or immediately while the datapath is idle.
    assign apply_c    = pend_vld_q & (boundary_c | ~ctrl.enable);
    // Only a real rate change discards datapath state.
    assign change_c   = apply_c & (pend_q != rate_q);
    assign reload_c   = apply_c ? 7'(pend_q - 8'd1) : 7'(rate_q - 8'd1);

`ifdef CIC_DEC_CTRL_FLUSH_EN
    localparam int unsigned FLUSH_W = (FLUSH_OUTS < 2) ? 1 : $clog2(FLUSH_OUTS + 1);
    logic [FLUSH_W-1:0] flush_q, flush_d;

    assign flush_act_c = (flush_q != '0);

    // Flush counter: loaded on a clearing apply, counts down on suppressed boundaries.
    always_comb begin
        flush_d = flush_q;
        if (change_c)                      flush_d = FLUSH_W'(FLUSH_OUTS);
        else if (boundary_c && flush_act_c) flush_d = flush_q - FLUSH_W'(1);
    end

    // Flush counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) flush_q <= '0;
        else          flush_q <= flush_d;
    end
`else
    // FLUSH_OUTS has no effect without the flush feature.
    logic unused_flush_outs;
    assign unused_flush_outs = (FLUSH_OUTS != 0);
    assign flush_act_c       = 1'b0;
`endif

    // Next-state: enable tracking, counter, rate/shift apply, pending register, strobes.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sint_d     = ctrl.enable & ctrl.strobe_in;
        scic_d     = boundary_c & ~change_c & ~flush_act_c;
        clr_d      = change_c;

        case (state_q)
            S_IDLE: begin
                if (ctrl.enable) begin
                    state_d = S_RUN;
                    clr_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (!ctrl.enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!ctrl.enable || boundary_c) cnt_d = reload_c;
        else if (ctrl.strobe_in)        cnt_d = cnt_q - 7'd1;

        if (apply_c) begin
            rate_d     = pend_q;
            shift_d    = bitgain(pend_q);
            pend_vld_d = 1'b0;
        end

        if (ctrl.rate_stb) begin
            pend_d     = coerce(ctrl.rate_in);
            pend_vld_d = 1'b1;
        end

`ifdef CIC_DEC_CTRL_FLUSH_EN
        busy_d = pend_vld_d | (flush_d != '0);
`else
        busy_d = pend_vld_d;
`endif
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rate_q     <= DEFAULT_RATE;
            shift_q    <= bitgain(DEFAULT_RATE);
            cnt_q      <= 7'(DEFAULT_RATE - 8'd1);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sint_q     <= 1'b0;
            scic_q     <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sint_q     <= sint_d;
            scic_q     <= scic_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
        end
    end

    assign ctrl.strobe_int  = sint_q;
    assign ctrl.strobe_cic  = scic_q;
    assign ctrl.clear_out   = clr_q;
    assign ctrl.shift       = shift_q;
    assign ctrl.rate_active = rate_q;
    assign ctrl.busy        = busy_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Testbench for cic_dec_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a sample-counting reference model.
module tb_cic_dec_ctrl;

`ifdef CIC_DEC_CTRL_FLUSH_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    cic_dec_ctrl_if bus ();

    cic_dec_ctrl #(
        .DEFAULT_RATE (8'd4),
        .FLUSH_OUTS   (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: samples gathered in the current block, rate, pending (-1 none).
    int m_rate, m_pend, m_nsamp, m_flush;
    bit m_en_prev;
    bit e_int, e_cic, e_clr;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gain(input int r);
        longint p;
        int s;
        p = longint'(r) * r * r * r;
        s = 0;
        while ((64'd1 << s) < p) s++;
        return s;
    endfunction

    function automatic int coerce(input int r);
        if (r == 0)   return 1;
        if (r > 128)  return 128;
        return r;
    endfunction

    task automatic model_reset();
        m_rate = 4; m_pend = -1; m_nsamp = 0; m_flush = 0; m_en_prev = 0;
        e_int = 0; e_cic = 0; e_clr = 0;
    endtask

    task automatic model_step(input bit en, input bit sin, input bit stb, input int rin);
        bit boundary, apply, changed;
        boundary = en && sin && (m_nsamp + 1 == m_rate);
        apply    = (m_pend >= 0) && (boundary || !en);
        changed  = apply && (m_pend != m_rate);
        e_int = en && sin;
        e_cic = boundary && !changed && (m_flush == 0);
        e_clr = changed || (en && !m_en_prev);
        if (!en)      m_nsamp = 0;
        else if (sin) m_nsamp = boundary ? 0 : m_nsamp + 1;
        if (changed)                     m_flush = FL;
        else if (boundary && m_flush > 0) m_flush--;
        if (apply) begin
            m_rate = m_pend;
            m_pend = -1;
        end
        if (stb) m_pend = coerce(rin);
        m_en_prev = en;
    endtask

    task automatic check_outputs();
        check("strobe_int",  int'(bus.strobe_int),  int'(e_int));
        check("strobe_cic",  int'(bus.strobe_cic),  int'(e_cic));
        check("clear_out",   int'(bus.clear_out),   int'(e_clr));
        check("rate_active", int'(bus.rate_active), m_rate);
        check("shift",       int'(bus.shift),       gain(m_rate));
        check("busy",        int'(bus.busy),        int'((m_pend >= 0) || (m_flush > 0)));
    endtask

    // One clock: check previous edge's outputs, drive new inputs, advance model.
    task automatic step(input bit en, input bit sin, input bit stb, input int rin);
        @(negedge clock);
        check_outputs();
        bus.enable    = en;
        bus.strobe_in = sin;
        bus.rate_stb  = stb;
        bus.rate_in   = 8'(rin);
        model_step(en, sin, stb, rin);
    endtask

    task automatic run(input int n, input bit en, input bit sin);
        for (int i = 0; i < n; i++) step(en, sin, 1'b0, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        check_outputs();
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.strobe_in = 1'b0;
        bus.rate_stb  = 1'b0;
        bus.rate_in   = 8'd0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clock);
        check_outputs();
        reset_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Apply a rate quickly by idling the datapath for a cycle.
    task automatic set_rate(input int r);
        step(1'b0, 1'b0, 1'b1, r);
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.strobe_in = 1'b0;
        bus.rate_stb  = 1'b0;
        bus.rate_in   = 8'd0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs();
        check("reset_shift_const", int'(bus.shift), 8);
        reset_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0, 0);

        // 1: default rate, strobe every cycle
        run(13, 1'b1, 1'b1);

        // 2: rate change to 10 mid-count
        step(1'b1, 1'b1, 1'b1, 10);
        run(40, 1'b1, 1'b1);
        check("t2_rate", int'(bus.rate_active), 10);
        check("t2_shift", int'(bus.shift), 14);

        // 3: coercion of 0 and 200
        step(1'b1, 1'b1, 1'b1, 0);
        run(14, 1'b1, 1'b1);
        check("t3_rate_lo", int'(bus.rate_active), 1);
        check("t3_shift_lo", int'(bus.shift), 0);
        step(1'b1, 1'b1, 1'b1, 200);
        run(3, 1'b1, 1'b1);
        check("t3_rate_hi", int'(bus.rate_active), 128);
        check("t3_shift_hi", int'(bus.shift), 28);
        set_rate(4);
        run(40, 1'b1, 1'b1);

        // 4: rate_stb coincident with a boundary, then back-to-back writes
        for (int i = 0; i < 8 && m_nsamp != m_rate - 1; i++) step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 8);
        step(1'b1, 1'b0, 1'b0, 0);
        check("t4_rate_hold", int'(bus.rate_active), 4);
        check("t4_busy", int'(bus.busy), 1);
        run(6, 1'b1, 1'b1);
        check("t4_rate_8", int'(bus.rate_active), 8);
        step(1'b1, 1'b1, 1'b1, 16);
        step(1'b1, 1'b1, 1'b1, 32);
        run(12, 1'b1, 1'b1);
        check("t4_rate_32", int'(bus.rate_active), 32);
        check("t4_shift_32", int'(bus.shift), 20);

        // 5: 4 -> 8 with flush behaviour
        set_rate(4);
        run(40, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8);
        run(60, 1'b1, 1'b1);
        check("t5_rate", int'(bus.rate_active), 8);

        // 6: enable toggle and reset pulse mid-count
        run(3, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 20);
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, 0);
        check("t6_rate", int'(bus.rate_active), 4);
        check("t6_busy", int'(bus.busy), 0);
        run(10, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit en, sin, stb;
            int rin;
            en  = ($urandom_range(0, 19) != 0);
            sin = ($urandom_range(0, 9) < 7);
            stb = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 7))
                0:       rin = 0;
                1:       rin = $urandom_range(129, 255);
                2:       rin = $urandom_range(0, 255);
                default: rin = $urandom_range(1, 12);
            endcase
            if ($urandom_range(0, 799) == 0) pulse_reset();
            else                             step(en, sin, stb, rin);
        end
        step(1'b0, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
